// File: rtl/dma_stream_master_if.sv
// dma_stream_master_if: Wishbone master and AXI-Stream out/in signal bundle
interface dma_stream_master_if;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic        wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_i;
  logic [31:0] wbs_dat_i;
  logic        sm_tvalid_o;
  logic [31:0] sm_tdata_o;
  logic        sm_tlast_o;
  logic        sm_tready_i;
  logic        ss_tvalid_i;
  logic [31:0] ss_tdata_i;
  logic        ss_tlast_i;
  logic        ss_tready_o;
  modport master (
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_ack_i, wbs_dat_i,
    output sm_tvalid_o, sm_tdata_o, sm_tlast_o,
    input  sm_tready_i,
    input  ss_tvalid_i, ss_tdata_i, ss_tlast_i,
    output ss_tready_o
  );
  modport slave (
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    output wbs_ack_i, wbs_dat_i,
    input  sm_tvalid_o, sm_tdata_o, sm_tlast_o,
    output sm_tready_i,
    output ss_tvalid_i, ss_tdata_i, ss_tlast_i,
    input  ss_tready_o
  );
endinterface

// File: rtl/dma_stream_master.sv
// dma_stream_master: streams RAM words out over AXI-Stream and writes returned stream words back to RAM
module dma_stream_master #(
  parameter int LEN_W = 12
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 ap_start_i,
  input  logic [31:0]          src_adr_i,
  input  logic [31:0]          dst_adr_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tlast_err_o,
  dma_stream_master_if.master  bus
);
  typedef enum logic {IDLE, RUN} top_t;
  typedef enum logic [1:0] {B_IDLE, B_RD, B_WR} bus_t;
  top_t             top_q, top_d;
  bus_t             bus_q, bus_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [31:0]      ob_dat_q, ob_dat_d, ib_dat_q, ib_dat_d;
  logic [LEN_W-1:0] len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             ob_full_q, ob_full_d, ib_full_q, ib_full_d;
  logic             terr_q, terr_d, last_wr_q, last_wr_d, done_q, done_d;
  logic             run, start, rd_pend, wr_pend, rd_ack, wr_ack;
  logic             ss_rdy, ss_fire, complete, in_bus;
  // channel requests, handshakes and end-of-transfer detection
  always_comb begin
    run      = top_q == RUN;
    start    = !run && ap_start_i;
    in_bus   = bus_q == B_RD || bus_q == B_WR;
    rd_pend  = run && rd_cnt_q < len_q && !ob_full_q;
    wr_pend  = ib_full_q;
    rd_ack   = bus_q == B_RD && bus.wbs_ack_i;
    wr_ack   = bus_q == B_WR && bus.wbs_ack_i;
    ss_rdy   = run && !ib_full_q && wr_cnt_q < len_q;
    ss_fire  = ss_rdy && bus.ss_tvalid_i;
    complete = run && rd_cnt_q == len_q && !ob_full_q && wr_cnt_q == len_q && bus_q == B_IDLE;
  end
  // next state: top FSM, bus arbiter, counters and the two one-word buffers
  always_comb begin
    top_d     = start && len_i != '0 ? RUN : complete ? IDLE : top_q;
    bus_d     = in_bus ? (bus.wbs_ack_i ? B_IDLE : bus_q) :
                rd_pend && (!wr_pend || last_wr_q) ? B_RD :
                wr_pend ? B_WR : B_IDLE;
    src_d     = start ? src_adr_i & 32'hFFFF_FFFC : src_q;
    dst_d     = start ? dst_adr_i & 32'hFFFF_FFFC : dst_q;
    len_d     = start ? len_i : len_q;
    rd_cnt_d  = start ? '0 : rd_cnt_q + LEN_W'(rd_ack);
    wr_cnt_d  = start ? '0 : wr_cnt_q + LEN_W'(wr_ack);
    ob_full_d = rd_ack || (ob_full_q && !bus.sm_tready_i);
    ob_dat_d  = rd_ack ? bus.wbs_dat_i : ob_dat_q;
    ib_full_d = ss_fire || (ib_full_q && !wr_ack);
    ib_dat_d  = ss_fire ? bus.ss_tdata_i : ib_dat_q;
    terr_d    = start ? 1'b0 :
                terr_q || (ss_fire && (bus.ss_tlast_i != ((wr_cnt_q + LEN_W'(1)) == len_q)));
    last_wr_d = rd_ack ? 1'b0 : wr_ack ? 1'b1 : last_wr_q;
    done_d    = start && len_i == '0;
  end
  // state registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      top_q     <= IDLE;
      bus_q     <= B_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ob_full_q <= 1'b0;
      ob_dat_q  <= '0;
      ib_full_q <= 1'b0;
      ib_dat_q  <= '0;
      terr_q    <= 1'b0;
      last_wr_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      top_q     <= top_d;
      bus_q     <= bus_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ob_full_q <= ob_full_d;
      ob_dat_q  <= ob_dat_d;
      ib_full_q <= ib_full_d;
      ib_dat_q  <= ib_dat_d;
      terr_q    <= terr_d;
      last_wr_q <= last_wr_d;
      done_q    <= done_d;
    end
  end
  // bus, stream and status outputs
  always_comb begin
    bus.wbs_cyc_o   = in_bus;
    bus.wbs_stb_o   = in_bus;
    bus.wbs_we_o    = bus_q == B_WR;
    bus.wbs_sel_o   = in_bus ? 4'hF : 4'h0;
    bus.wbs_adr_o   = bus_q == B_RD ? src_q + (32'(rd_cnt_q) << 2) :
                      bus_q == B_WR ? dst_q + (32'(wr_cnt_q) << 2) : '0;
    bus.wbs_dat_o   = bus_q == B_WR ? ib_dat_q : '0;
    bus.sm_tvalid_o = ob_full_q;
    bus.sm_tdata_o  = ob_dat_q;
    bus.sm_tlast_o  = ob_full_q && rd_cnt_q == len_q;
    bus.ss_tready_o = ss_rdy;
    busy_o          = run;
    done_o          = done_q || complete;
    tlast_err_o     = terr_q;
  end
endmodule

// File: doc/dma_stream_master.md
Name: dma_stream_master

Overview:
- Wishbone classic master that feeds the DMA-side request port of the CPU/DMA RAM arbiter.
- Streams LEN words read from RAM (starting at SRC) out on an AXI-Stream master port to the accelerator.
- Concurrently accepts LEN words from the accelerator's AXI-Stream slave port and writes them to RAM (starting at DST).
- Read and write traffic share the single Wishbone port under internal alternating priority.

Parameters:
LEN_W, 12, width of transfer length in 32-bit words (max 2^LEN_W-1 words)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-low
ap_start_i  in  1  one-cycle start pulse; ignored unless idle
src_adr_i  in  32  RAM read base byte address (bits[1:0] ignored)
dst_adr_i  in  32  RAM write base byte address (bits[1:0] ignored)
len_i  in  LEN_W  words to read and to write
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle completion pulse
wbs_cyc_o  out  1  Wishbone cycle
wbs_stb_o  out  1  Wishbone strobe
wbs_we_o  out  1  1=write, 0=read
wbs_sel_o  out  4  byte select, always 4'hF when stb high
wbs_adr_o  out  32  word-aligned byte address
wbs_dat_o  out  32  write data
wbs_ack_i  in  1  Wishbone acknowledge
wbs_dat_i  in  32  read data
sm_tvalid_o  out  1  stream-out valid
sm_tdata_o  out  32  stream-out data
sm_tlast_o  out  1  high on last stream-out word
sm_tready_i  in  1  stream-out ready
ss_tvalid_i  in  1  stream-in valid
ss_tdata_i  in  32  stream-in data
ss_tlast_i  in  1  stream-in last
ss_tready_o  out  1  stream-in ready
tlast_err_o  out  1  sticky: ss_tlast_i disagreed with the expected final word; cleared on next start

Behaviour:
- Reset (wb_rst_i=0, asynchronous): all outputs 0, counters 0, buffers empty, top FSM IDLE, bus FSM B_IDLE, last-served=write.
- Top FSM IDLE -> RUN on ap_start_i. Latch src/dst (bits[1:0] forced 0) and len. Clear rd_cnt, wr_cnt, tlast_err_o. busy_o=1 the next cycle.
- Start with len_i=0: no bus or stream activity; done_o pulses the cycle after start; busy_o stays 0.
- ap_start_i while busy_o=1 is ignored.
- Read channel: 1-entry out buffer.
  - Read pending when rd_cnt<len and out buffer empty.
  - On read ack: buffer <= wbs_dat_i, sm_tvalid_o=1 the next cycle, rd_cnt++.
  - sm_tlast_o=1 when the buffered word is word len-1.
  - Buffer empties on sm_tvalid_o&sm_tready_i; sm_tdata_o is held stable while valid and not ready.
- Write channel: 1-entry in buffer.
  - ss_tready_o = buffer empty & (wr_cnt + buffered) < len & RUN.
  - On ss handshake, capture data; write becomes pending.
  - On write ack: buffer empties, wr_cnt++.
  - tlast_err_o sets if ss_tlast_i on an accepted beat differs from (beat index == len-1).
- Bus FSM:
  - B_IDLE: if both pending, serve the opposite of last-served; else serve whichever is pending. Next cycle enter B_RD or B_WR.
  - B_RD/B_WR: cyc=stb=1, sel=F, we per state, adr = base + 4*count (32-bit wrap). Outputs held until wbs_ack_i.
  - On ack: update last-served and return to B_IDLE. cyc/stb are low for at least 1 cycle between transactions.
  - Minimum 3 cycles per word per channel, assuming a 1-cycle ack.
- Completion: RUN -> IDLE when rd_cnt==len, out buffer empty, wr_cnt==len and bus in B_IDLE. done_o pulses that cycle and busy_o falls next cycle.
- A stalled sm_tready_i does not block writes, and vice versa.

Test Plan:
- Reset mid-transfer (len=8, after 3 reads) -> all outputs 0 immediately; a new start with len=2 runs cleanly from the new bases.
- src=0x100, dst=0x200, len=4, RAM[0x100..0x10C]=1,2,3,4, ready always 1, ss fed 0xA..0xD -> sm_tdata 1,2,3,4 with tlast on 4; RAM[0x200..0x20C]=A,B,C,D; one done_o pulse.
- Both channels pending every cycle -> Wishbone we pattern alternates R,W,R,W; cyc low ≥1 cycle between acks.
- sm_tready_i=0 for 20 cycles after first read -> exactly 1 read issued, sm_tdata stable; writes continue to completion.
- len=0 start -> done_o pulse next cycle, no cyc, busy_o stays 0.
- ss_tlast_i asserted on beat 1 of len=3 -> tlast_err_o=1, transfer still completes 3 writes; next start clears it.
